// File: rtl/ofifo_collector_if.sv
// Bus interface for ofifo_collector: south-edge capture inputs, row pop
// request, and the registered row output with its status flags.
// master = array/consumer side, slave = the collector.
interface ofifo_collector_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64,
    localparam int AW     = $clog2(depth)
);
    logic [psum_bw*col-1:0] in;
    logic [col-1:0]         wr;
    logic                   rd;
    logic [psum_bw*col-1:0] out;
    logic                   o_valid;
    logic                   o_ready;
    logic                   o_full;
    logic                   out_vld;
    logic [AW:0]            level;
    logic                   ovf;
    logic                   udf;

    modport master (
        output in, wr, rd,
        input  out, o_valid, o_ready, o_full, out_vld, level, ovf, udf
    );

    modport slave (
        input  in, wr, rd,
        output out, o_valid, o_ready, o_full, out_vld, level, ovf, udf
    );
endinterface

// File: rtl/ofifo_collector.sv
// Output staging stage below the systolic MAC array. Each column owns a
// circular FIFO that absorbs the diagonal skew of the array's south outputs;
// complete rows (one word per column) are popped together into a registered
// output. Optional build macro OFIFO_RELU_EN clamps negative words to zero
// on the way out (buffered data is never modified).
module ofifo_collector #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64,
    localparam int AW     = $clog2(depth)
) (
    input logic               clk,
    input logic               reset,
    ofifo_collector_if.slave  bus
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [psum_bw-1:0]     mem [col][depth];
    logic [AW:0]            wr_ptr [col];
    logic [AW:0]            rd_ptr;        // columns always pop together, so one read pointer serves all
    logic [AW:0]            occ [col];
    logic [col-1:0]         full;
    logic [col-1:0]         empty;
    logic [col-1:0]         we;
    logic [AW:0]            lvl;
    logic                   row_avail;
    logic                   do_rd;
    logic                   drop;
    logic [psum_bw*col-1:0] head_row;
    logic [psum_bw*col-1:0] out_q;
    logic                   out_vld_q;
    logic                   ovf_q;
    logic                   udf_q;

    // Per-column status derived purely from the registered pointers.
    always_comb begin
        for (int c = 0; c < col; c++) begin
            full[c]  = (wr_ptr[c][AW] != rd_ptr[AW]) && (wr_ptr[c][AW-1:0] == rd_ptr[AW-1:0]);
            empty[c] = (wr_ptr[c] == rd_ptr);
            occ[c]   = wr_ptr[c] - rd_ptr;
            we[c]    = bus.wr[c] && !full[c];
        end
    end

    // Complete rows held = smallest column occupancy.
    // NOTE: combinational blocks use blocking '=' so later statements see the
    // updated running minimum; clocked state below uses '<=' exclusively.
    always_comb begin
        lvl = occ[0];
        for (int c = 1; c < col; c++) begin
            if (occ[c] < lvl) lvl = occ[c];
        end
    end

    assign row_avail = ~|empty;
    assign do_rd     = bus.rd && row_avail;
    assign drop      = |(bus.wr & full);

    // Head word of every column, optionally ReLU-clamped, ready to load into out.
    always_comb begin
        head_row = '0;
        for (int c = 0; c < col; c++) begin
`ifdef OFIFO_RELU_EN
            if (mem[c][rd_ptr[AW-1:0]][psum_bw-1])
                head_row[c*psum_bw +: psum_bw] = '0;
            else
                head_row[c*psum_bw +: psum_bw] = mem[c][rd_ptr[AW-1:0]];
`else
            head_row[c*psum_bw +: psum_bw] = mem[c][rd_ptr[AW-1:0]];
`endif
        end
    end

    // Column storage: capture each accepted south-edge word at its write pointer.
    // NOTE: the storage array has no reset; pointers reset to empty, so stale
    // contents are unreachable and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (we[c]) mem[c][wr_ptr[c][AW-1:0]] <= bus.in[c*psum_bw +: psum_bw];
        end
    end

    // Pointers, registered row output and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < col; c++) wr_ptr[c] <= '0;
            rd_ptr    <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            for (int c = 0; c < col; c++) begin
                if (we[c]) wr_ptr[c] <= wr_ptr[c] + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                out_q  <= head_row;
            end
            out_vld_q <= do_rd;
            if (drop) ovf_q <= 1'b1;
            if (bus.rd && !row_avail) udf_q <= 1'b1;
        end
    end

    assign bus.out     = out_q;
    assign bus.out_vld = out_vld_q;
    assign bus.o_valid = row_avail;
    assign bus.o_ready = ~|full;
    assign bus.o_full  = |full;
    assign bus.level   = lvl;
    assign bus.ovf     = ovf_q;
    assign bus.udf     = udf_q;

endmodule

// File: tb/tb_ofifo_collector.sv
// Directed testbench for ofifo_collector: reset, skewed column capture,
// full/overflow, simultaneous push+pop, underflow, pointer wrap and the
// optional ReLU output clamp. Expected rows are queued when written and
// popped when the collector releases them.
module tb_ofifo_collector;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int DEP = 64;
    localparam int W   = COL*BW;

    logic clk;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] sb [$];
    logic [W-1:0] last_out;

    ofifo_collector_if #(.col(COL), .psum_bw(BW), .depth(DEP)) bus ();

    ofifo_collector #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] row_of(input int r);
        logic [W-1:0] v;
        v = '0;
        for (int c = 0; c < COL; c++) v[c*BW +: BW] = {r[7:0], 8'(c)};
        return v;
    endfunction

    function automatic logic [W-1:0] fill_row(input logic [BW-1:0] w);
        logic [W-1:0] v;
        for (int c = 0; c < COL; c++) v[c*BW +: BW] = w;
        return v;
    endfunction

    task automatic wr_row(input logic [W-1:0] d);
        bus.in = d;
        bus.wr = '1;
        cyc();
        bus.wr = '0;
        sb.push_back(d);
    endtask

    task automatic rd_row(input string tag);
        logic [W-1:0] exp;
        bus.rd = 1'b1;
        cyc();
        bus.rd = 1'b0;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed read with empty scoreboard expected queued row", tag);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_vld"}, W'(bus.out_vld), W'(1));
            chk(tag, bus.out, exp);
            last_out = exp;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        sb.delete();
        last_out = '0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        logic [W-1:0] row;
        logic [W-1:0] exp6;

        bus.in = '0;
        bus.wr = '0;
        bus.rd = 1'b0;
        rst_n  = 1'b0;
        last_out = '0;
        cyc();
        cyc();

        chk("rst_o_valid", W'(bus.o_valid), W'(0));
        chk("rst_o_ready", W'(bus.o_ready), W'(1));
        chk("rst_o_full",  W'(bus.o_full),  W'(0));
        chk("rst_level",   W'(bus.level),   W'(0));
        chk("rst_out",     bus.out,         W'(0));
        chk("rst_out_vld", W'(bus.out_vld), W'(0));
        chk("rst_ovf",     W'(bus.ovf),     W'(0));
        chk("rst_udf",     W'(bus.udf),     W'(0));
        rst_n = 1'b1;
        cyc();

        // Skewed capture: column c writes c+1 on cycle c; row completes only after column 7.
        row = '0;
        for (int c = 0; c < COL; c++) begin
            bus.in = fill_row(16'hDEAD);
            bus.in[c*BW +: BW] = 16'(c + 1);
            row[c*BW +: BW] = 16'(c + 1);
            bus.wr = COL'(1) << c;
            cyc();
            bus.wr = '0;
            chk($sformatf("skew_o_valid_c%0d", c), W'(bus.o_valid), W'(c == COL-1));
        end
        sb.push_back(row);
        rd_row("skew_row");
        cyc();
        chk("idle_out_vld", W'(bus.out_vld), W'(0));
        chk("idle_out_hold", bus.out, last_out);

        // Read while empty: underflow flag, output holds.
        bus.rd = 1'b1;
        cyc();
        bus.rd = 1'b0;
        chk("udf_flag",    W'(bus.udf),     W'(1));
        chk("udf_out_vld", W'(bus.out_vld), W'(0));
        chk("udf_out",     bus.out,         last_out);
        chk("udf_level",   W'(bus.level),   W'(0));

        // Mid-stream asynchronous reset discards buffered rows and sticky flags.
        for (int r = 0; r < 5; r++) wr_row(row_of(r));
        chk("pre_rst_level", W'(bus.level), W'(5));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_o_valid", W'(bus.o_valid), W'(0));
        chk("mid_rst_level",   W'(bus.level),   W'(0));
        chk("mid_rst_o_ready", W'(bus.o_ready), W'(1));
        chk("mid_rst_out",     bus.out,         W'(0));
        chk("mid_rst_ovf",     W'(bus.ovf),     W'(0));
        chk("mid_rst_udf",     W'(bus.udf),     W'(0));
        sb.delete();
        last_out = '0;
        cyc();
        rst_n = 1'b1;
        cyc();

        // Fill to depth, overflow one column, then drain in order.
        for (int r = 0; r < DEP; r++) wr_row(row_of(r));
        chk("full_o_full",  W'(bus.o_full),  W'(1));
        chk("full_o_ready", W'(bus.o_ready), W'(0));
        chk("full_level",   W'(bus.level),   W'(DEP));
        chk("full_ovf_pre", W'(bus.ovf),     W'(0));
        bus.in = fill_row(16'hBEEF);
        bus.wr = 8'h08;
        cyc();
        bus.wr = '0;
        chk("ovf_flag",  W'(bus.ovf),   W'(1));
        chk("ovf_level", W'(bus.level), W'(DEP));
        for (int r = 0; r < DEP; r++) rd_row($sformatf("drain_%0d", r));
        chk("drained_o_valid", W'(bus.o_valid), W'(0));
        chk("drained_level",   W'(bus.level),   W'(0));

        // Simultaneous push and pop while full: pop wins, writes dropped.
        do_reset();
        for (int r = 0; r < DEP; r++) wr_row(row_of(r + 100));
        bus.in = fill_row(16'h7777);
        bus.wr = '1;
        rd_row("full_push_pop");
        bus.wr = '0;
        chk("full_pp_ovf",   W'(bus.ovf),   W'(1));
        chk("full_pp_level", W'(bus.level), W'(DEP - 1));
        for (int r = 0; r < DEP - 1; r++) rd_row($sformatf("full_pp_drain_%0d", r));
        chk("full_pp_empty", W'(bus.o_valid), W'(0));

        // Simultaneous push and pop at level 10: occupancy unchanged.
        for (int r = 0; r < 10; r++) wr_row(row_of(r + 40));
        chk("l10_level", W'(bus.level), W'(10));
        bus.in = row_of(99);
        bus.wr = '1;
        sb.push_back(row_of(99));
        rd_row("l10_push_pop");
        bus.wr = '0;
        chk("l10_level_after", W'(bus.level), W'(10));
        for (int r = 0; r < 10; r++) rd_row($sformatf("l10_drain_%0d", r));

        // Pointer wrap: 200 write/read pairs.
        for (int i = 0; i < 200; i++) begin
            wr_row(fill_row(16'(i * 3 + 1)) ^ row_of(i));
            rd_row($sformatf("wrap_%0d", i));
        end
        chk("wrap_level", W'(bus.level), W'(0));

        // Sign handling on the output path.
        for (int c = 0; c < COL; c++) begin
            row[c*BW +: BW] = (c % 2 == 0) ? 16'hFFF6 : 16'h000A;
`ifdef OFIFO_RELU_EN
            exp6[c*BW +: BW] = (c % 2 == 0) ? 16'h0000 : 16'h000A;
`else
            exp6[c*BW +: BW] = (c % 2 == 0) ? 16'hFFF6 : 16'h000A;
`endif
        end
        wr_row(row);
        sb.pop_back();
        sb.push_back(exp6);
        rd_row("relu_row");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
